scr1_ialu_mdu: RTL and testbench
================================

# scr1_ialu_mdu

Iterative multiply/divide unit that answers the IALU's RVM (MUL/DIV) handshake. It accepts `exu2ialu_rvm_cmd_vd_i` together with an MDU opcode and two operands. It computes the RV32M result over multiple cycles and returns it with a one-cycle `ialu2exu_rvm_res_rdy_o` strobe. It sits beside the main ALU/address adder inside the IALU and is the responder end of the EXU↔IALU MUL/DIV handshake.

## Interface
- `SCR1_XLEN`, 32: operand/result width (global define, not a module parameter).
- `clk` in 1: single clock; all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `exu2ialu_rvm_cmd_vd_i` in 1: MUL/DIV command valid; held high by EXU until the result strobe.
- `exu2ialu_cmd_i` in `type_scr1_ialu_cmd_sel_e`: opcode; only MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU are accepted.
- `exu2ialu_main_op1_i` in 32: rs1 (multiplicand/dividend).
- `exu2ialu_main_op2_i` in 32: rs2 (multiplier/divisor).
- `ialu2exu_rvm_res_rdy_o` out 1: result ready, one-cycle pulse.
- `ialu2exu_rvm_res_o` out 32: result; valid only while ready is high, 0 otherwise.
- `ialu2exu_rvm_busy_o` out 1: high in ITER state.

## Operation
- States: IDLE, ITER, DONE.
- IDLE:
  - Valid high with an MDU opcode → latch opcode and operands, go to ITER, counter = 0.
  - Valid high with a non-MDU opcode → ignored; stay in IDLE.
- Early-terminate cases go IDLE→DONE directly, with no ITER cycles:
  - DIV/DIVU by zero → quotient 0xFFFFFFFF.
  - REM/REMU by zero → dividend.
  - DIV with 0x80000000 / 0xFFFFFFFF → 0x80000000; REM with the same operands → 0.
- ITER runs 32 cycles, counter 0..31; the transition to DONE happens at counter 31.
  - Multiply: shift-add on operand magnitudes, 64-bit accumulator.
    - Operand sign rules: op1 is signed for MULH/MULHSU; op2 is signed for MULH only.
    - The product is negated at the end if the operand signs differ.
    - MUL returns bits [31:0]; all other multiplies return bits [63:32].
  - Divide: restoring division on magnitudes (signed ops) or raw values (unsigned ops), one quotient bit per cycle.
    - Quotient is negated if operand signs differ.
    - Remainder takes the sign of the dividend.
- DONE: lasts exactly one cycle. `res_rdy_o`=1 and `res_o` is driven; next state is IDLE.
- Operand and opcode inputs are ignored after latching.
- Abort: valid low in any ITER cycle → IDLE on the next edge. No ready is produced and the partial result is discarded.
- Valid low in the DONE cycle → the strobe is still issued.
- Reset, asynchronous and possibly mid-operation:
  - State returns to IDLE and the counter to 0.
  - All outputs go to 0 immediately.
  - Internal datapath registers are cleared.

## Timing
- Cycle 0 = first cycle in which valid is sampled high in IDLE.
- Iterative op: ready in cycle 33, busy high in cycles 1–32.
- Early-terminate op: ready in cycle 1.
- The EXU drops valid in the cycle after ready.
  - If valid is still high in the first IDLE cycle after DONE, it is treated as a new command (back-to-back, no dead cycle beyond DONE).
- Minimum command spacing: ready cycle + 1.
- Output reset values: `res_rdy_o`=0, `res_o`=0, `busy_o`=0.

## Configuration
- `SCR1_MDU_FAST_MUL_EN`
  - Defined: the four multiply opcodes use a single combinational 33×33 signed multiplier. IDLE→DONE, ready in cycle 1, busy never high for multiplies. Division is unchanged.
  - Undefined: multiplies use the 32-cycle iterative path with ready in cycle 33; no hardware multiplier is inferred.

## Test plan
- MUL 7 × 0xFFFFFFFD (−3) → res 0xFFFFFFEB, ready only in cycle 33 (cycle 1 with `SCR1_MDU_FAST_MUL_EN`), busy high cycles 1–32.
- High-half multiplies:
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- Signed and unsigned division:
  - DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD.
  - REM with the same operands → 0xFFFFFFFF.
  - DIVU 100 / 7 → 14.
  - REMU 100 / 7 → 2.
  - Each gives ready in cycle 33.
- Early-terminate cases, each with ready in cycle 1 and busy never asserted:
  - DIV 5 / 0 → 0xFFFFFFFF.
  - REMU 5 / 0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - REM with the same operands → 0.
- Abort: start DIVU, drop valid in cycle 10 → no ready, IDLE in cycle 11. New MUL 3 × 4 issued in cycle 11 → 12 with ready 33 cycles later.
- Reset mid-op: assert `rst` during cycle 20 of a DIV → ready/res/busy 0 without a clock edge. After release, valid must restart from cycle 0 and produce the correct result.

Source files
------------

// File: rtl/scr1_ialu_mdu.sv
// rtl/scr1_ialu_mdu.sv - iterative RV32M multiply/divide unit; optional single-cycle multiply via SCR1_MDU_FAST_MUL_EN
`ifndef SCR1_XLEN
`define SCR1_XLEN 32
`endif

package scr1_ialu_mdu_pkg;
  typedef enum logic [4:0] {
    SCR1_IALU_CMD_NONE    = 5'd0,
    SCR1_IALU_CMD_AND     = 5'd1,
    SCR1_IALU_CMD_OR      = 5'd2,
    SCR1_IALU_CMD_XOR     = 5'd3,
    SCR1_IALU_CMD_ADD     = 5'd4,
    SCR1_IALU_CMD_SUB     = 5'd5,
    SCR1_IALU_CMD_SUB_LT  = 5'd6,
    SCR1_IALU_CMD_SUB_LTU = 5'd7,
    SCR1_IALU_CMD_SUB_EQ  = 5'd8,
    SCR1_IALU_CMD_SUB_NE  = 5'd9,
    SCR1_IALU_CMD_SUB_GE  = 5'd10,
    SCR1_IALU_CMD_SUB_GEU = 5'd11,
    SCR1_IALU_CMD_SLL     = 5'd12,
    SCR1_IALU_CMD_SRL     = 5'd13,
    SCR1_IALU_CMD_SRA     = 5'd14,
    SCR1_IALU_CMD_MUL     = 5'd15,
    SCR1_IALU_CMD_MULHU   = 5'd16,
    SCR1_IALU_CMD_MULHSU  = 5'd17,
    SCR1_IALU_CMD_MULH    = 5'd18,
    SCR1_IALU_CMD_DIV     = 5'd19,
    SCR1_IALU_CMD_DIVU    = 5'd20,
    SCR1_IALU_CMD_REM     = 5'd21,
    SCR1_IALU_CMD_REMU    = 5'd22
  } type_scr1_ialu_cmd_sel_e;
endpackage

module scr1_ialu_mdu
  import scr1_ialu_mdu_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     exu2ialu_rvm_cmd_vd_i,
  input  type_scr1_ialu_cmd_sel_e  exu2ialu_cmd_i,
  input  logic [`SCR1_XLEN-1:0]    exu2ialu_main_op1_i,
  input  logic [`SCR1_XLEN-1:0]    exu2ialu_main_op2_i,
  output logic                     ialu2exu_rvm_res_rdy_o,
  output logic [`SCR1_XLEN-1:0]    ialu2exu_rvm_res_o,
  output logic                     ialu2exu_rvm_busy_o
);

  localparam int XLEN = `SCR1_XLEN;

  typedef enum logic [1:0] {ST_IDLE, ST_ITER, ST_DONE} state_e;

  state_e                  r_state, w_state_nxt;
  logic [4:0]              r_cnt;
  type_scr1_ialu_cmd_sel_e r_cmd;
  logic [XLEN-1:0]         r_opb;      // multiplicand or divisor magnitude
  logic [2*XLEN-1:0]       r_acc;      // mul: {partial sum, multiplier}; div: {remainder, dividend/quotient}
  logic                    r_neg;      // product/quotient must be negated
  logic                    r_rem_neg;  // remainder takes dividend sign
  logic [XLEN-1:0]         r_res;

  logic            w_in_mul, w_in_div, w_in_s1, w_in_s2, w_in_quo, w_in_sdiv;
  logic            w_op1_neg, w_op2_neg;
  logic [XLEN-1:0] w_op1_mag, w_op2_mag;
  logic            w_div_zero, w_div_ovf, w_early, w_fast, w_start;
  logic [XLEN-1:0] w_early_res, w_fast_res;

  logic [XLEN:0]     w_mul_sum;
  logic [XLEN:0]     w_shl;
  logic              w_ge;
  logic [XLEN-1:0]   w_sub;
  logic [2*XLEN-1:0] w_acc_nxt, w_prod;
  logic [XLEN-1:0]   w_quo, w_rem, w_fin_res;

  // Classify the incoming opcode: operation kind and operand signedness
  always_comb begin
    w_in_mul  = 1'b0;
    w_in_div  = 1'b0;
    w_in_s1   = 1'b0;
    w_in_s2   = 1'b0;
    w_in_quo  = 1'b0;
    w_in_sdiv = 1'b0;
    case (exu2ialu_cmd_i)
      SCR1_IALU_CMD_MUL:    w_in_mul = 1'b1;
      SCR1_IALU_CMD_MULHU:  w_in_mul = 1'b1;
      SCR1_IALU_CMD_MULHSU: begin w_in_mul = 1'b1; w_in_s1 = 1'b1; end
      SCR1_IALU_CMD_MULH:   begin w_in_mul = 1'b1; w_in_s1 = 1'b1; w_in_s2 = 1'b1; end
      SCR1_IALU_CMD_DIV:    begin w_in_div = 1'b1; w_in_s1 = 1'b1; w_in_s2 = 1'b1; w_in_quo = 1'b1; w_in_sdiv = 1'b1; end
      SCR1_IALU_CMD_DIVU:   begin w_in_div = 1'b1; w_in_quo = 1'b1; end
      SCR1_IALU_CMD_REM:    begin w_in_div = 1'b1; w_in_s1 = 1'b1; w_in_s2 = 1'b1; w_in_sdiv = 1'b1; end
      SCR1_IALU_CMD_REMU:   w_in_div = 1'b1;
      default: ;
    endcase
  end

  assign w_op1_neg  = w_in_s1 & exu2ialu_main_op1_i[XLEN-1];
  assign w_op2_neg  = w_in_s2 & exu2ialu_main_op2_i[XLEN-1];
  assign w_op1_mag  = w_op1_neg ? -exu2ialu_main_op1_i : exu2ialu_main_op1_i;
  assign w_op2_mag  = w_op2_neg ? -exu2ialu_main_op2_i : exu2ialu_main_op2_i;

  assign w_div_zero = w_in_div & (exu2ialu_main_op2_i == '0);
  assign w_div_ovf  = w_in_sdiv & (exu2ialu_main_op1_i == {1'b1, {(XLEN-1){1'b0}}})
                                & (exu2ialu_main_op2_i == '1);
  assign w_early    = w_div_zero | w_div_ovf;
  assign w_early_res = w_div_zero ? (w_in_quo ? '1 : exu2ialu_main_op1_i)
                                  : (w_in_quo ? {1'b1, {(XLEN-1){1'b0}}} : '0);

`ifdef SCR1_MDU_FAST_MUL_EN
  logic [2*XLEN-1:0] w_fast_a, w_fast_b, w_fast_prod;
  // Sign-extended 33-bit operands; only the low 64 product bits are needed
  assign w_fast_a    = {{XLEN{w_op1_neg}}, exu2ialu_main_op1_i};
  assign w_fast_b    = {{XLEN{w_op2_neg}}, exu2ialu_main_op2_i};
  assign w_fast_prod = w_fast_a * w_fast_b;
  assign w_fast_res  = (exu2ialu_cmd_i == SCR1_IALU_CMD_MUL) ? w_fast_prod[XLEN-1:0]
                                                             : w_fast_prod[2*XLEN-1:XLEN];
  assign w_fast      = w_in_mul;
`else
  assign w_fast_res  = '0;
  assign w_fast      = 1'b0;
`endif

  assign w_start = (r_state == ST_IDLE) & exu2ialu_rvm_cmd_vd_i & (w_in_mul | w_in_div);

  // One iteration step: shift-add multiply or restoring divide
  always_comb begin
    w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opb} : '0);
    w_shl     = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
    w_ge      = (w_shl >= {1'b0, r_opb});
    w_sub     = w_shl[XLEN-1:0] - r_opb;
    if ((r_cmd == SCR1_IALU_CMD_MUL)    || (r_cmd == SCR1_IALU_CMD_MULH) ||
        (r_cmd == SCR1_IALU_CMD_MULHSU) || (r_cmd == SCR1_IALU_CMD_MULHU)) begin
      w_acc_nxt = {w_mul_sum, r_acc[XLEN-1:1]};
    end else begin
      w_acc_nxt = {(w_ge ? w_sub : w_shl[XLEN-1:0]), r_acc[XLEN-2:0], w_ge};
    end
  end

  // Sign fix-up and result selection from the final accumulator value
  always_comb begin
    w_prod = r_neg ? -w_acc_nxt : w_acc_nxt;
    w_quo  = r_neg ? -w_acc_nxt[XLEN-1:0] : w_acc_nxt[XLEN-1:0];
    w_rem  = r_rem_neg ? -w_acc_nxt[2*XLEN-1:XLEN] : w_acc_nxt[2*XLEN-1:XLEN];
    case (r_cmd)
      SCR1_IALU_CMD_MUL:    w_fin_res = w_prod[XLEN-1:0];
      SCR1_IALU_CMD_MULH,
      SCR1_IALU_CMD_MULHSU,
      SCR1_IALU_CMD_MULHU:  w_fin_res = w_prod[2*XLEN-1:XLEN];
      SCR1_IALU_CMD_DIV,
      SCR1_IALU_CMD_DIVU:   w_fin_res = w_quo;
      default:              w_fin_res = w_rem;
    endcase
  end

  // Next-state logic; a dropped valid during ITER aborts the operation
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_start) w_state_nxt = (w_early | w_fast) ? ST_DONE : ST_ITER;
      ST_ITER: begin
        if (!exu2ialu_rvm_cmd_vd_i)  w_state_nxt = ST_IDLE;
        else if (r_cnt == 5'd31)     w_state_nxt = ST_DONE;
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register and iteration counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= ((r_state == ST_ITER) && (w_state_nxt == ST_ITER)) ? r_cnt + 5'd1 : '0;
    end
  end

  // Datapath: latch operands on accept, step each ITER cycle, capture result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cmd     <= SCR1_IALU_CMD_NONE;
      r_opb     <= '0;
      r_acc     <= '0;
      r_neg     <= 1'b0;
      r_rem_neg <= 1'b0;
      r_res     <= '0;
    end else if (w_start) begin
      r_cmd     <= exu2ialu_cmd_i;
      r_neg     <= w_op1_neg ^ w_op2_neg;
      r_rem_neg <= w_op1_neg;
      r_opb     <= w_in_mul ? w_op1_mag : w_op2_mag;
      r_acc     <= {{XLEN{1'b0}}, (w_in_mul ? w_op2_mag : w_op1_mag)};
      if (w_early)     r_res <= w_early_res;
      else if (w_fast) r_res <= w_fast_res;
    end else if ((r_state == ST_ITER) && exu2ialu_rvm_cmd_vd_i) begin
      r_acc <= w_acc_nxt;
      if (r_cnt == 5'd31) r_res <= w_fin_res;
    end
  end

  assign ialu2exu_rvm_res_rdy_o = (r_state == ST_DONE);
  assign ialu2exu_rvm_res_o     = (r_state == ST_DONE) ? r_res : '0;
  assign ialu2exu_rvm_busy_o    = (r_state == ST_ITER);

endmodule

// File: tb/tb_scr1_ialu_mdu.sv
// tb/tb_scr1_ialu_mdu.sv - scoreboard testbench for scr1_ialu_mdu
module tb_scr1_ialu_mdu;
  import scr1_ialu_mdu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic vd  = 1'b0;
  type_scr1_ialu_cmd_sel_e cmd = SCR1_IALU_CMD_NONE;
  logic [31:0] op1 = '0, op2 = '0;
  logic        rdy, busy;
  logic [31:0] res;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int bz_lo = 1, bz_hi = 0;
  bit at_done = 1'b0;

  typedef struct {
    logic [31:0]             res;
    int                      cyc;
    type_scr1_ialu_cmd_sel_e cmd;
  } exp_t;
  exp_t q[$];
  exp_t mon_e;

  type_scr1_ialu_cmd_sel_e mdu_cmds [8] = '{SCR1_IALU_CMD_MUL, SCR1_IALU_CMD_MULH,
    SCR1_IALU_CMD_MULHSU, SCR1_IALU_CMD_MULHU, SCR1_IALU_CMD_DIV, SCR1_IALU_CMD_DIVU,
    SCR1_IALU_CMD_REM, SCR1_IALU_CMD_REMU};

  scr1_ialu_mdu dut (
    .clk                    (clk),
    .rst                    (rst),
    .exu2ialu_rvm_cmd_vd_i  (vd),
    .exu2ialu_cmd_i         (cmd),
    .exu2ialu_main_op1_i    (op1),
    .exu2ialu_main_op2_i    (op2),
    .ialu2exu_rvm_res_rdy_o (rdy),
    .ialu2exu_rvm_res_o     (res),
    .ialu2exu_rvm_busy_o    (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ref_res(input type_scr1_ialu_cmd_sel_e c,
                                          input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sa, sb, za, zb, p;
    int ia, ib;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    za = {32'b0, a};
    zb = {32'b0, b};
    ia = a;
    ib = b;
    case (c)
      SCR1_IALU_CMD_MUL:    begin p = za * zb; return p[31:0];  end
      SCR1_IALU_CMD_MULH:   begin p = sa * sb; return p[63:32]; end
      SCR1_IALU_CMD_MULHSU: begin p = sa * zb; return p[63:32]; end
      SCR1_IALU_CMD_MULHU:  begin p = za * zb; return p[63:32]; end
      SCR1_IALU_CMD_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return ia / ib;
      end
      SCR1_IALU_CMD_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      SCR1_IALU_CMD_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input type_scr1_ialu_cmd_sel_e c,
                                 input logic [31:0] a, input logic [31:0] b);
    bit is_div, is_sdiv;
    is_div  = (c == SCR1_IALU_CMD_DIV) || (c == SCR1_IALU_CMD_DIVU) ||
              (c == SCR1_IALU_CMD_REM) || (c == SCR1_IALU_CMD_REMU);
    is_sdiv = (c == SCR1_IALU_CMD_DIV) || (c == SCR1_IALU_CMD_REM);
    if (is_div && b == 0) return 1;
    if (is_sdiv && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef SCR1_MDU_FAST_MUL_EN
    if (!is_div) return 1;
`endif
    return 33;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Monitor: compares every presented result against the scoreboard head
  always @(negedge clk) begin
    if (!rst) begin
      tests++;
      if (busy !== ((cyc >= bz_lo) && (cyc <= bz_hi))) begin
        fails++;
        $display("FAIL busy at cycle %0d: got %b expected %b", cyc, busy, !busy);
      end
      if (rdy) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_ready at cycle %0d res %h", cyc, res);
        end else begin
          mon_e = q.pop_front();
          if (res !== mon_e.res) begin
            fails++;
            $display("FAIL result %s: got %h expected %h", mon_e.cmd.name(), res, mon_e.res);
          end
          tests++;
          if (cyc != mon_e.cyc) begin
            fails++;
            $display("FAIL latency %s: ready at cycle %0d expected %0d", mon_e.cmd.name(), cyc, mon_e.cyc);
          end
        end
      end else begin
        tests++;
        if (res !== 32'h0) begin
          fails++;
          $display("FAIL res_not_ready at cycle %0d: got %h expected 0", cyc, res);
        end
      end
    end
  end

  task automatic issue(input type_scr1_ialu_cmd_sel_e c, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int c0, lat;
    c0    = at_done ? cyc + 1 : cyc;
    lat   = exp_lat(c, a, b);
    e.res = ref_res(c, a, b);
    e.cyc = c0 + lat;
    e.cmd = c;
    q.push_back(e);
    if (lat > 1) begin bz_lo = c0 + 1; bz_hi = c0 + 32; end
    else         begin bz_lo = 1;      bz_hi = 0;       end
    vd = 1'b1; cmd = c; op1 = a; op2 = b;
    at_done = 1'b0;
  endtask

  task automatic wait_rdy();
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!rdy && n < 40);
    if (!rdy) begin
      tests++; fails++;
      $display("FAIL timeout waiting for ready at cycle %0d", cyc);
      q.delete();
      vd = 1'b0;
    end
    at_done = rdy;
  endtask

  task automatic run(input type_scr1_ialu_cmd_sel_e c, input logic [31:0] a, input logic [31:0] b);
    issue(c, a, b);
    wait_rdy();
  endtask

  task automatic drop();
    vd = 1'b0;
    at_done = 1'b0;
    @(negedge clk);
  endtask

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    type_scr1_ialu_cmd_sel_e rc;
    #1;
    check("reset_rdy",  {31'b0, rdy},  32'h0);
    check("reset_res",  res,           32'h0);
    check("reset_busy", {31'b0, busy}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run(SCR1_IALU_CMD_MUL,    32'd7,         32'hFFFF_FFFD); drop();
    run(SCR1_IALU_CMD_MULH,   32'h8000_0000, 32'h8000_0000); drop();
    run(SCR1_IALU_CMD_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF); drop();
    run(SCR1_IALU_CMD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF); drop();
    run(SCR1_IALU_CMD_DIV,    32'hFFFF_FFF9, 32'd2);         drop();
    run(SCR1_IALU_CMD_REM,    32'hFFFF_FFF9, 32'd2);         drop();
    run(SCR1_IALU_CMD_DIVU,   32'd100,       32'd7);         drop();
    run(SCR1_IALU_CMD_REMU,   32'd100,       32'd7);         drop();
    run(SCR1_IALU_CMD_DIV,    32'd5,         32'd0);         drop();
    run(SCR1_IALU_CMD_REMU,   32'd5,         32'd0);         drop();
    run(SCR1_IALU_CMD_DIV,    32'h8000_0000, 32'hFFFF_FFFF); drop();
    run(SCR1_IALU_CMD_REM,    32'h8000_0000, 32'hFFFF_FFFF); drop();

    // Non-MDU opcode with valid high is ignored
    vd = 1'b1; cmd = SCR1_IALU_CMD_ADD; op1 = 32'd1; op2 = 32'd2;
    repeat (5) @(negedge clk);
    drop();

    // Back-to-back commands with no dead cycle
    run(SCR1_IALU_CMD_DIVU, 32'd1000, 32'd3);
    run(SCR1_IALU_CMD_MUL,  32'd3,    32'd4);
    run(SCR1_IALU_CMD_REM,  32'd5,    32'd0);
    run(SCR1_IALU_CMD_MULHU, 32'h1234_5678, 32'h9ABC_DEF0);
    drop();

    // Abort: valid dropped in cycle 10, new MUL in cycle 11
    c0 = cyc;
    vd = 1'b1; cmd = SCR1_IALU_CMD_DIVU; op1 = 32'd123456; op2 = 32'd7;
    bz_lo = c0 + 1; bz_hi = c0 + 32;
    repeat (10) @(negedge clk);
    vd = 1'b0;
    bz_hi = c0 + 10;
    @(negedge clk);
    run(SCR1_IALU_CMD_MUL, 32'd3, 32'd4);
    drop();

    // Reset in cycle 20 of a DIV, then restart from cycle 0
    c0 = cyc;
    vd = 1'b1; cmd = SCR1_IALU_CMD_DIV; op1 = 32'h8765_4321; op2 = 32'd13;
    bz_lo = c0 + 1; bz_hi = c0 + 32;
    repeat (20) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("midop_reset_busy", {31'b0, busy}, 32'h0);
    check("midop_reset_rdy",  {31'b0, rdy},  32'h0);
    check("midop_reset_res",  res,           32'h0);
    q.delete();
    bz_lo = 1; bz_hi = 0;
    vd = 1'b0;
    at_done = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run(SCR1_IALU_CMD_DIV, 32'h8765_4321, 32'd13);
    drop();

    // Reset during the DONE cycle clears the strobe and result at once
    run(SCR1_IALU_CMD_REMU, 32'hCAFE_F00D, 32'd0);
    #1 rst = 1'b1;
    #1;
    check("done_reset_rdy", {31'b0, rdy}, 32'h0);
    check("done_reset_res", res,          32'h0);
    vd = 1'b0;
    at_done = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Randomized operations, sometimes back-to-back
    for (int i = 0; i < 150; i++) begin
      rc = mdu_cmds[$urandom_range(0, 7)];
      run(rc, rnd_op(), rnd_op());
      if ($urandom_range(0, 3) != 0) drop();
    end
    drop();

    repeat (3) @(negedge clk);
    check("scoreboard_empty", q.size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
